// File: rtl/apb4_completer_mem_if.sv
// APB4 bus bundle between a requester and the memory completer.
// Requester drives address/control/data; completer returns read data and response.
interface apb4_completer_mem_if #(
  parameter int unsigned AddressWidth = 20,
  parameter int unsigned DataWidth    = 32
);
  localparam int unsigned StrbW = DataWidth / 8;

  logic [AddressWidth-1:0] paddr;
  logic                    pwrite;
  logic                    psel;
  logic                    penable;
  logic [DataWidth-1:0]    pwdata;
  logic [StrbW-1:0]        pstrb;
  logic [2:0]              pprot;
  logic [DataWidth-1:0]    prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_completer_mem.sv
// APB4 completer in front of a word-addressed memory with byte strobes,
// per-direction wait states and PSLVERR on out-of-range or non-secure access.
module apb4_completer_mem #(
  parameter int unsigned AddressWidth    = 20,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned MemDepthWords   = 1024,
  parameter int unsigned ReadWaitStates  = 0,
  parameter int unsigned WriteWaitStates = 0,
  parameter int unsigned SecureOnly      = 0
) (
  input logic                clk,
  input logic                rst_n,
  apb4_completer_mem_if.slave apb
);

  localparam int unsigned StrbW  = DataWidth / 8;
  localparam int unsigned ByteAw = $clog2(StrbW);
  localparam int unsigned IdxW   = AddressWidth - ByteAw;
  localparam int unsigned MemAw  = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;
  localparam int unsigned CntW   = 4;

  localparam logic [IdxW:0]     DepthC   = (IdxW + 1)'(MemDepthWords);
  localparam logic [CntW-1:0]   RdWaitC  = CntW'(ReadWaitStates);
  localparam logic [CntW-1:0]   WrWaitC  = CntW'(WriteWaitStates);
  localparam bit                SecureC  = (SecureOnly != 0);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [MemAw-1:0]       idx_q, idx_d;
  logic                   write_q, write_d;
  logic                   err_q, err_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [DataWidth-1:0]   prdata_q, prdata_d;

  logic [DataWidth-1:0]   mem [MemDepthWords];

  logic [IdxW-1:0]        idx_c;
  logic                   err_c;
  logic                   setup_c;
  logic [CntW-1:0]        wait_c;
  logic [MemAw-1:0]       rd_addr_c;
  logic [DataWidth-1:0]   rd_word_c;
  logic                   fin_c;
  logic                   fin_err_c;
  logic                   fin_wr_c;
  logic                   we_c;
  logic                   unused_c;

  // Request decode: word index, error classification and wait-state selection.
  assign idx_c   = apb.paddr[AddressWidth-1:ByteAw];
  assign err_c   = ({1'b0, idx_c} >= DepthC) || (SecureC && apb.pprot[1]);
  assign setup_c = apb.psel && !apb.penable;
  assign wait_c  = apb.pwrite ? WrWaitC : RdWaitC;

  // With zero wait states the read word must come straight off the live address.
  assign rd_addr_c = (state_q == IDLE) ? idx_c[MemAw-1:0] : idx_q;
  assign rd_word_c = mem[rd_addr_c];

  // Low address bits and the unused protection bits carry no meaning here.
  assign unused_c = ^{apb.pprot, apb.paddr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Next-state and registered-response logic; pready_q high marks the completion cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    fin_c     = 1'b0;
    fin_err_c = err_q;
    fin_wr_c  = write_q;
    we_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (setup_c) begin
          idx_d   = idx_c[MemAw-1:0];
          write_d = apb.pwrite;
          err_d   = err_c;
          cnt_d   = wait_c;
          state_d = ACCESS;
          if (wait_c == '0) begin
            fin_c     = 1'b1;
            fin_err_c = err_c;
            fin_wr_c  = apb.pwrite;
          end
        end
      end
      ACCESS: begin
        if (pready_q) begin
          we_c    = write_q && apb.psel && apb.penable && !err_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!apb.psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CntW'(1)) begin
          cnt_d = '0;
          fin_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pready_d  = fin_c;
    pslverr_d = fin_c && fin_err_c;
    prdata_d  = prdata_q;
    if (fin_c && !fin_wr_c) begin
      prdata_d = fin_err_c ? '0 : rd_word_c;
    end
  end

  // Write data and strobes are taken in the completion cycle itself.
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int unsigned i = 0; i < StrbW; i++) begin
        if (apb.pstrb[i]) begin
          mem[idx_q][8*i +: 8] <= apb.pwdata[8*i +: 8];
        end
      end
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_completer_mem.sv
// Bench for apb4_completer_mem: three configurations share one driven bus,
// psel picks the target; a word-array model predicts data, errors and latency.
module tb_apb4_completer_mem;

  logic        clk;
  logic        rst_n;
  logic [19:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [2:0]  psel_v;

  logic [31:0] prdata_v  [3];
  logic        pready_v  [3];
  logic        pslverr_v [3];

  int n_cmp;
  int n_bad;

  // Per-DUT configuration: read waits, write waits, secure-only.
  int unsigned rws [3] = '{0, 3, 0};
  int unsigned wws [3] = '{0, 1, 4};
  bit          sec [3] = '{1'b0, 1'b1, 1'b0};

  logic [31:0] mdl     [3][1024];
  logic [31:0] last_rd [3];

  apb4_completer_mem_if #(.AddressWidth(20), .DataWidth(32)) if0 ();
  apb4_completer_mem_if #(.AddressWidth(20), .DataWidth(32)) if1 ();
  apb4_completer_mem_if #(.AddressWidth(20), .DataWidth(32)) if2 ();

  assign if0.paddr = paddr;  assign if1.paddr = paddr;  assign if2.paddr = paddr;
  assign if0.pwrite = pwrite; assign if1.pwrite = pwrite; assign if2.pwrite = pwrite;
  assign if0.penable = penable; assign if1.penable = penable; assign if2.penable = penable;
  assign if0.pwdata = pwdata; assign if1.pwdata = pwdata; assign if2.pwdata = pwdata;
  assign if0.pstrb = pstrb;  assign if1.pstrb = pstrb;  assign if2.pstrb = pstrb;
  assign if0.pprot = pprot;  assign if1.pprot = pprot;  assign if2.pprot = pprot;
  assign if0.psel = psel_v[0];
  assign if1.psel = psel_v[1];
  assign if2.psel = psel_v[2];

  assign prdata_v[0] = if0.prdata;  assign pready_v[0] = if0.pready;  assign pslverr_v[0] = if0.pslverr;
  assign prdata_v[1] = if1.prdata;  assign pready_v[1] = if1.pready;  assign pslverr_v[1] = if1.pslverr;
  assign prdata_v[2] = if2.prdata;  assign pready_v[2] = if2.pready;  assign pslverr_v[2] = if2.pslverr;

  apb4_completer_mem #(
    .AddressWidth(20), .DataWidth(32), .MemDepthWords(1024),
    .ReadWaitStates(0), .WriteWaitStates(0), .SecureOnly(0)
  ) dut0 (.clk(clk), .rst_n(rst_n), .apb(if0));

  apb4_completer_mem #(
    .AddressWidth(20), .DataWidth(32), .MemDepthWords(1024),
    .ReadWaitStates(3), .WriteWaitStates(1), .SecureOnly(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .apb(if1));

  apb4_completer_mem #(
    .AddressWidth(20), .DataWidth(32), .MemDepthWords(1024),
    .ReadWaitStates(0), .WriteWaitStates(4), .SecureOnly(0)
  ) dut2 (.clk(clk), .rst_n(rst_n), .apb(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an access errors if the word index is beyond depth or it is
  // non-secure on a secure-only target; a clean write merges the strobed bytes.
  function automatic bit mdl_err(input int d, input logic [19:0] a, input logic [2:0] pr);
    int unsigned idx;
    idx = int'(a[19:2]);
    return (idx >= 1024) || (sec[d] && pr[1]);
  endfunction

  function automatic void mdl_write(input int d, input logic [19:0] a, input logic [31:0] wd,
                                    input logic [3:0] st, input logic [2:0] pr);
    int unsigned idx;
    idx = int'(a[19:2]);
    if (mdl_err(d, a, pr)) return;
    for (int b = 0; b < 4; b++)
      if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
  endfunction

  function automatic logic [31:0] mdl_read(input int d, input logic [19:0] a, input logic [2:0] pr);
    if (mdl_err(d, a, pr)) return 32'h0;
    return mdl[d][int'(a[19:2])];
  endfunction

  // One APB transfer; returns the response seen in the completion cycle and its
  // length in cycles counted from the setup cycle.
  task automatic xfer(input int d, input logic wr, input logic [19:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int cyc);
    @(negedge clk);
    psel_v    = 3'b000;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
    pstrb     = st;
    pprot     = pr;
    cyc       = 1;
    @(negedge clk);
    penable = 1'b1;
    cyc     = 2;
    while (pready_v[d] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    rd = prdata_v[d];
    er = pslverr_v[d];
    if (pready_v[d] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d addr=%h: pready never rose within %0d cycles", d, a, cyc);
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    psel_v  = 3'b000;
    penable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (pready_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_pready dut%0d: got %b want 0", k, pready_v[k]); end
      n_cmp++;
      if (pslverr_v[k] !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr dut%0d: got %b want 0", k, pslverr_v[k]); end
      n_cmp++;
      if (prdata_v[k] !== 32'h0) begin n_bad++; $display("FAIL reset_prdata dut%0d: got %h want 0", k, prdata_v[k]); end
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int cyc;
    xfer(0, 1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, cyc);
    mdl_write(0, 20'h00010, 32'hDEADBEEF, 4'hF, 3'b000);
    n_cmp++;
    if (cyc !== 2 || er !== 1'b0) begin n_bad++; $display("FAIL basic_write: cycles=%0d err=%b want 2/0", cyc, er); end
    xfer(0, 1'b0, 20'h00010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || cyc !== 2) begin
      n_bad++; $display("FAIL basic_read: data=%h err=%b cycles=%0d want DEADBEEF/0/2", rd, er, cyc);
    end
    bus_idle();
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int cyc;
    xfer(0, 1'b1, 20'h00010, 32'h11223344, 4'h5, 3'b000, rd, er, cyc);
    mdl_write(0, 20'h00010, 32'h11223344, 4'h5, 3'b000);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL partial_hold_prdata: got %h want DEADBEEF", rd); end
    xfer(0, 1'b0, 20'h00012, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'hDE22BE44 || er !== 1'b0) begin n_bad++; $display("FAIL partial_read: data=%h err=%b want DE22BE44/0", rd, er); end
    xfer(0, 1'b1, 20'h00010, 32'h55555555, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL zero_strobe_err: got %b want 0", er); end
    xfer(0, 1'b0, 20'h00010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'hDE22BE44) begin n_bad++; $display("FAIL zero_strobe_read: got %h want DE22BE44", rd); end
    bus_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int cyc;
    xfer(1, 1'b1, 20'h00010, 32'hA5A55A5A, 4'hF, 3'b000, rd, er, cyc);
    mdl_write(1, 20'h00010, 32'hA5A55A5A, 4'hF, 3'b000);
    n_cmp++;
    if (cyc !== 3 || er !== 1'b0) begin n_bad++; $display("FAIL ws_write: cycles=%0d err=%b want 3/0", cyc, er); end
    xfer(1, 1'b0, 20'h00010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (cyc !== 5 || rd !== 32'hA5A55A5A || er !== 1'b0) begin
      n_bad++; $display("FAIL ws_read: cycles=%0d data=%h err=%b want 5/A5A55A5A/0", cyc, rd, er);
    end
    bus_idle();
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int cyc;
    xfer(0, 1'b1, 20'h00000, 32'h01234567, 4'hF, 3'b000, rd, er, cyc);
    mdl_write(0, 20'h00000, 32'h01234567, 4'hF, 3'b000);
    xfer(0, 1'b0, 20'h01000, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h0 || cyc !== 2) begin
      n_bad++; $display("FAIL oor_read: err=%b data=%h cycles=%0d want 1/0/2", er, rd, cyc);
    end
    xfer(0, 1'b1, 20'h01000, 32'hFFFFFFFF, 4'hF, 3'b000, rd, er, cyc);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL oor_write_err: got %b want 1", er); end
    xfer(0, 1'b0, 20'h00000, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'h01234567 || er !== 1'b0) begin n_bad++; $display("FAIL oor_no_alias: data=%h err=%b want 01234567/0", rd, er); end
    bus_idle();
  endtask

  task automatic test_secure();
    logic [31:0] rd; logic er; int cyc;
    xfer(1, 1'b1, 20'h00040, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, cyc);
    mdl_write(1, 20'h00040, 32'hCAFEF00D, 4'hF, 3'b000);
    xfer(1, 1'b1, 20'h00040, 32'h0BADBEEF, 4'hF, 3'b010, rd, er, cyc);
    n_cmp++;
    if (er !== 1'b1) begin n_bad++; $display("FAIL nonsecure_write_err: got %b want 1", er); end
    xfer(1, 1'b0, 20'h00040, 32'h0, 4'h0, 3'b010, rd, er, cyc);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL nonsecure_read: err=%b data=%h want 1/0", er, rd); end
    xfer(1, 1'b0, 20'h00040, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin n_bad++; $display("FAIL nonsecure_unchanged: data=%h err=%b want CAFEF00D/0", rd, er); end
    xfer(1, 1'b1, 20'h00040, 32'h0BADBEEF, 4'hF, 3'b101, rd, er, cyc);
    mdl_write(1, 20'h00040, 32'h0BADBEEF, 4'hF, 3'b101);
    n_cmp++;
    if (er !== 1'b0) begin n_bad++; $display("FAIL secure_write_err: got %b want 0", er); end
    xfer(1, 1'b0, 20'h00040, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'h0BADBEEF) begin n_bad++; $display("FAIL secure_commit: got %h want 0BADBEEF", rd); end
    bus_idle();
  endtask

  // penable high in IDLE without a setup phase must be ignored.
  task automatic test_idle_penable();
    logic [31:0] rd; logic er; int cyc;
    xfer(0, 1'b1, 20'h00028, 32'h28282828, 4'hF, 3'b000, rd, er, cyc);
    mdl_write(0, 20'h00028, 32'h28282828, 4'hF, 3'b000);
    bus_idle();
    @(negedge clk);
    psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 20'h00028;
    pwdata = 32'hBAD0BAD0; pstrb = 4'hF; pprot = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pready_v[0] !== 1'b0) begin n_bad++; $display("FAIL idle_penable_pready cycle%0d: got %b want 0", i, pready_v[0]); end
    end
    xfer(0, 1'b0, 20'h00028, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== mdl_read(0, 20'h00028, 3'b000)) begin n_bad++; $display("FAIL idle_penable_nowrite: got %h want %h", rd, mdl_read(0, 20'h00028, 3'b000)); end
    bus_idle();
  endtask

  // Dropping psel mid-wait aborts the write with no response.
  task automatic test_abort();
    logic [31:0] rd; logic er; int cyc;
    xfer(2, 1'b1, 20'h00024, 32'h24242424, 4'hF, 3'b000, rd, er, cyc);
    mdl_write(2, 20'h00024, 32'h24242424, 4'hF, 3'b000);
    n_cmp++;
    if (cyc !== 6) begin n_bad++; $display("FAIL abort_prewrite_cycles: got %0d want 6", cyc); end
    @(negedge clk);
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00024;
    pwdata = 32'hFFFF0000; pstrb = 4'hF;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    psel_v = 3'b000; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pready_v[2] !== 1'b0) begin n_bad++; $display("FAIL abort_pready cycle%0d: got %b want 0", i, pready_v[2]); end
    end
    xfer(2, 1'b0, 20'h00024, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'h24242424 || cyc !== 2) begin n_bad++; $display("FAIL abort_nowrite: data=%h cycles=%0d want 24242424/2", rd, cyc); end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int cyc;
    xfer(2, 1'b1, 20'h00020, 32'h20202020, 4'hF, 3'b000, rd, er, cyc);
    mdl_write(2, 20'h00020, 32'h20202020, 4'hF, 3'b000);
    // Reset in the completion cycle of a read must clear the response immediately.
    xfer(0, 1'b0, 20'h00010, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pready_v[0] !== 1'b0 || prdata_v[0] !== 32'h0) begin
      n_bad++; $display("FAIL reset_async_dut0: pready=%b prdata=%h want 0/0", pready_v[0], prdata_v[0]);
    end
    psel_v = 3'b000; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00020;
    pwdata = 32'h99999999; pstrb = 4'hF;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pready_v[2] !== 1'b0 || pslverr_v[2] !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_write: pready=%b pslverr=%b want 0/0", pready_v[2], pslverr_v[2]);
    end
    psel_v = 3'b000; penable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
    xfer(2, 1'b0, 20'h00020, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    n_cmp++;
    if (rd !== 32'h20202020) begin n_bad++; $display("FAIL reset_discard_write: got %h want 20202020", rd); end
    bus_idle();
  endtask

  // Randomised back-to-back traffic on every configuration.
  task automatic test_back_to_back();
    logic [31:0] rd, wd, exp_rd;
    logic [19:0] a;
    logic [17:0] idx;
    logic [3:0]  st;
    logic [2:0]  pr;
    logic        er, wr, exp_er;
    int          cyc, exp_cyc;
    apply_reset();
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        a  = {18'(w), 2'b00};
        xfer(d, 1'b1, a, wd, 4'hF, 3'b000, rd, er, cyc);
        mdl_write(d, a, wd, 4'hF, 3'b000);
      end
      for (int n = 0; n < 60; n++) begin
        idx = ($urandom_range(0, 7) == 0) ? 18'(1024 + $urandom_range(0, 5000)) : 18'($urandom_range(0, 15));
        a   = {idx, 2'($urandom_range(0, 3))};
        wr  = 1'($urandom_range(0, 1));
        wd  = $urandom;
        st  = 4'($urandom_range(0, 15));
        pr  = 3'($urandom_range(0, 7));
        exp_er  = mdl_err(d, a, pr);
        exp_cyc = 2 + int'(wr ? wws[d] : rws[d]);
        exp_rd  = wr ? last_rd[d] : mdl_read(d, a, pr);
        xfer(d, wr, a, wd, st, pr, rd, er, cyc);
        if (wr) mdl_write(d, a, wd, st, pr);
        else    last_rd[d] = exp_rd;
        n_cmp++;
        if (rd !== exp_rd || er !== exp_er || cyc !== exp_cyc) begin
          n_bad++;
          $display("FAIL rand dut%0d #%0d %s addr=%h: data=%h err=%b cyc=%0d want %h/%b/%0d",
                   d, n, wr ? "wr" : "rd", a, rd, er, cyc, exp_rd, exp_er, exp_cyc);
        end
      end
      bus_idle();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    psel_v  = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = '0;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
    test_reset();
    test_basic();
    test_partial();
    test_wait_states();
    test_error();
    test_secure();
    test_idle_penable();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
